// File: rtl/alu_mul_ctrl.sv
// alu_mul_ctrl: shift-add multiply sequencer that borrows a shared combinational ALU
// Ports:
//   CLK, nRST            clock, synchronous active-low reset
//   START, IN_A, IN_B    multiply request and operands (accepted in IDLE only)
//   BUSY, DONE, OUT_P    CPU stall, one-cycle completion pulse, held product
//   CPU_*                decoder ALU request, forwarded to ALU_* while idle
//   ALU_*                shared ALU operand/instruction ports and its result/carry
module alu_mul_ctrl #(
  parameter int DWIDTH = 8,
  parameter int IWIDTH = 4
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  START,
  input  logic [DWIDTH-1:0]     IN_A,
  input  logic [DWIDTH-1:0]     IN_B,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [2*DWIDTH-1:0]   OUT_P,
  input  logic [IWIDTH-1:0]     CPU_INSTR,
  input  logic [DWIDTH-1:0]     CPU_A,
  input  logic [DWIDTH-1:0]     CPU_B,
  input  logic                  CPU_CIN,
  input  logic                  CPU_BIN,
  output logic [IWIDTH-1:0]     ALU_INSTR,
  output logic [DWIDTH-1:0]     ALU_A,
  output logic [DWIDTH-1:0]     ALU_B,
  output logic                  ALU_CIN,
  output logic                  ALU_BIN,
  input  logic [DWIDTH-1:0]     ALU_OUT,
  input  logic                  ALU_COUT
);
  localparam int CW = $clog2(DWIDTH) + 1;
  typedef enum logic [1:0] {IDLE, ADD, SHIFT, FIN} state_t;
  state_t state;
  logic [DWIDTH-1:0] m, acc, q;
  logic c;
  logic [CW-1:0] cnt;
  logic [DWIDTH-1:0] acc_sh, q_sh;
  // ALU rotate supplies ACC[DWIDTH-1:1]; the add carry becomes the new MSB
  assign acc_sh = {c, ALU_OUT[DWIDTH-2:0]};
  assign q_sh   = {acc[0], q[DWIDTH-1:1]};
  always_comb begin
    ALU_INSTR = state == IDLE ? CPU_INSTR : state == ADD ? IWIDTH'(4'h5) : state == SHIFT ? IWIDTH'(4'h6) : IWIDTH'(4'hF);
    ALU_A     = state == IDLE ? CPU_A : state == FIN ? '0 : acc;
    ALU_B     = state == IDLE ? CPU_B : (state == ADD && q[0]) ? m : '0;
    ALU_CIN   = state == IDLE && CPU_CIN;
    ALU_BIN   = state == IDLE && CPU_BIN;
  end
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= IDLE;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      OUT_P <= '0;
      m     <= '0;
      acc   <= '0;
      q     <= '0;
      c     <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (START) begin
          m     <= IN_A;
          q     <= IN_B;
          acc   <= '0;
          c     <= 1'b0;
          cnt   <= CW'(DWIDTH);
          BUSY  <= 1'b1;
          state <= ADD;
        end
        ADD: begin
          acc   <= ALU_OUT;
          c     <= ALU_COUT;
          state <= SHIFT;
        end
        SHIFT: begin
          acc   <= acc_sh;
          q     <= q_sh;
          cnt   <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            OUT_P <= {acc_sh, q_sh};
            DONE  <= 1'b1;
            state <= FIN;
          end else begin
            state <= ADD;
          end
        end
        default: begin
          DONE  <= 1'b0;
          BUSY  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_mul_ctrl.sv
// tb_alu_mul_ctrl: randomized self-checking bench for alu_mul_ctrl with a behavioural ALU
module tb_alu_mul_ctrl;
  logic CLK = 1'b0;
  logic nRST, START;
  logic [7:0] IN_A, IN_B;
  logic BUSY, DONE;
  logic [15:0] OUT_P;
  logic [3:0] CPU_INSTR, ALU_INSTR;
  logic [7:0] CPU_A, CPU_B, ALU_A, ALU_B, ALU_OUT;
  logic CPU_CIN, CPU_BIN, ALU_CIN, ALU_BIN, ALU_COUT;
  int checks = 0, failures = 0, cyc = 0, last_done = -1;
  logic [15:0] exp_p = '0;
  alu_mul_ctrl #(.DWIDTH(8), .IWIDTH(4)) dut (
    .CLK(CLK), .nRST(nRST), .START(START), .IN_A(IN_A), .IN_B(IN_B),
    .BUSY(BUSY), .DONE(DONE), .OUT_P(OUT_P),
    .CPU_INSTR(CPU_INSTR), .CPU_A(CPU_A), .CPU_B(CPU_B), .CPU_CIN(CPU_CIN), .CPU_BIN(CPU_BIN),
    .ALU_INSTR(ALU_INSTR), .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_CIN(ALU_CIN), .ALU_BIN(ALU_BIN),
    .ALU_OUT(ALU_OUT), .ALU_COUT(ALU_COUT)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  always_comb begin
    {ALU_COUT, ALU_OUT} = {1'b0, ALU_A ^ ALU_B};
    if (ALU_INSTR == 4'h5) {ALU_COUT, ALU_OUT} = 9'(ALU_A) + 9'(ALU_B) + 9'(ALU_CIN);
    if (ALU_INSTR == 4'h6) {ALU_COUT, ALU_OUT} = {1'b0, ALU_A[0], ALU_A[7:1]};
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @cyc %0d", tag, got, exp, cyc);
    end
  endtask
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic rand_cpu;
    CPU_INSTR = 4'($urandom);
    CPU_A = 8'($urandom);
    CPU_B = 8'($urandom);
    CPU_CIN = 1'($urandom);
    CPU_BIN = 1'($urandom);
  endtask
  task automatic pass_chk;
    rand_cpu();
    #1;
    check("pt_instr", ALU_INSTR, CPU_INSTR);
    check("pt_a", ALU_A, CPU_A);
    check("pt_b", ALU_B, CPU_B);
    check("pt_cin", ALU_CIN, CPU_CIN);
    check("pt_bin", ALU_BIN, CPU_BIN);
    check("pt_busy", BUSY, 0);
  endtask
  // Partial product after step i is a*(b mod 2^i); ACC holds it shifted right by i.
  task automatic run_mul(input logic [7:0] a, input logic [7:0] b, input bit noisy);
    int pa, pb;
    START = 1'b1;
    IN_A = a;
    IN_B = b;
    tick();
    START = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      rand_cpu();
      if (noisy) begin
        START = 1'($urandom);
        IN_A = 8'($urandom);
        IN_B = 8'($urandom);
      end
      #1;
      check("busy", BUSY, 1);
      check("done", DONE, k == 17);
      check("cin", ALU_CIN, 0);
      check("bin", ALU_BIN, 0);
      if (k <= 16) begin
        int i = (k - 1) / 2;
        pa = (k % 2) ? (int'(a) * (int'(b) & ((1 << i) - 1))) >> i
                     : ((int'(a) * (int'(b) & ((1 << (i + 1)) - 1))) >> i) & 255;
        pb = (k % 2) ? (b[i] ? int'(a) : 0) : 0;
        check("instr", ALU_INSTR, (k % 2) ? 4'h5 : 4'h6);
        check("alu_a", ALU_A, pa);
        check("alu_b", ALU_B, pb);
        check("outp_hold", OUT_P, exp_p);
      end else begin
        exp_p = 16'(int'(a) * int'(b));
        check("fin_instr", ALU_INSTR, 4'hF);
        check("fin_a", ALU_A, 0);
        check("fin_b", ALU_B, 0);
        check("product", OUT_P, exp_p);
        if (last_done >= 0) check("spacing", cyc - last_done, 18);
        last_done = cyc;
      end
      tick();
    end
    START = 1'b0;
    check("idle_busy", BUSY, 0);
    check("idle_done", DONE, 0);
    check("idle_outp", OUT_P, exp_p);
  endtask
  initial begin
    nRST = 1'b0;
    START = 1'b0;
    IN_A = '0;
    IN_B = '0;
    rand_cpu();
    tick();
    tick();
    nRST = 1'b1;
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_outp", OUT_P, 0);
    CPU_INSTR = 4'h5;
    CPU_A = 8'd3;
    CPU_B = 8'd4;
    #1;
    check("pt_dir_instr", ALU_INSTR, 4'h5);
    check("pt_dir_a", ALU_A, 3);
    check("pt_dir_b", ALU_B, 4);
    check("pt_dir_outp", OUT_P, 0);
    tick();
    run_mul(8'd13, 8'd11, 0);
    check("prod_13x11", OUT_P, 16'h008F);
    run_mul(8'hFF, 8'hFF, 0);
    check("prod_ffxff", OUT_P, 16'hFE01);
    run_mul(8'h80, 8'h02, 0);
    check("prod_80x02", OUT_P, 16'h0100);
    run_mul(8'h00, 8'h5A, 0);
    check("prod_0x5a", OUT_P, 16'h0000);
    run_mul(8'hC3, 8'hA7, 1);
    pass_chk();
    tick();
    START = 1'b1;
    IN_A = 8'hF1;
    IN_B = 8'h9D;
    tick();
    START = 1'b0;
    repeat (5) tick();
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    exp_p = '0;
    check("rst_mid_busy", BUSY, 0);
    check("rst_mid_done", DONE, 0);
    check("rst_mid_outp", OUT_P, 0);
    pass_chk();
    for (int k = 0; k < 20; k++) begin
      check("rst_no_done", DONE, 0);
      tick();
    end
    last_done = -1;
    run_mul(8'd7, 8'd9, 0);
    check("prod_7x9", OUT_P, 16'd63);
    for (int n = 0; n < 1000; n++) run_mul(8'($urandom), 8'($urandom), n % 10 == 0);
    pass_chk();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
